pipeline_hazard_controller: RTL and testbench

- Sequences the five-stage pipeline (F/D/E/M/W) around the decode controller's outputs.
- Generates operand-forwarding selects, load-use stalls, and branch/jump redirect flushes.
- Runs a data-memory request/ready handshake FSM that freezes the pipeline while a load/store is outstanding.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout error.

---
 rtl/pipeline_hazard_controller_pkg.sv | 16 +
 rtl/pipeline_hazard_controller_forwarding_unit.sv | 24 ++
 rtl/pipeline_hazard_controller.sv | 143 ++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// rtl/pipeline_hazard_controller_pkg.sv - shared enums for the hazard controller
package HighLevelControl;

  typedef enum logic [1:0] {
    RegFile   = 2'b00,
    WriteBack = 2'b01,
    Memory    = 2'b10
  } forwardSrc;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    ERROR = 2'b10
  } memState;

endpackage

// File: rtl/pipeline_hazard_controller_forwarding_unit.sv
// rtl/pipeline_hazard_controller_forwarding_unit.sv - operand forward select for one source register
module forwarding_unit
  import HighLevelControl::*;
#(
  parameter int REG_ADDR_BITS = 5
) (
  input  logic [REG_ADDR_BITS-1:0] rs,
  input  logic [REG_ADDR_BITS-1:0] rd_m,
  input  logic                     reg_write_m,
  input  logic [REG_ADDR_BITS-1:0] rd_w,
  input  logic                     reg_write_w,
  output forwardSrc                fwd
);

  // Memory stage holds the younger result, so it wins over writeback; x0 never forwards.
  always_comb begin
    fwd = RegFile;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs))
      fwd = Memory;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs))
      fwd = WriteBack;
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush/forward sequencing and data-memory handshake FSM
module pipeline_hazard_controller
  import HighLevelControl::*;
#(
  parameter int REG_ADDR_BITS = 5,
  parameter int MEM_TIMEOUT   = 64,
  parameter int CNT_BITS      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REG_ADDR_BITS-1:0] Rs1D,
  input  logic [REG_ADDR_BITS-1:0] Rs2D,
  input  logic [REG_ADDR_BITS-1:0] Rs1E,
  input  logic [REG_ADDR_BITS-1:0] Rs2E,
  input  logic [REG_ADDR_BITS-1:0] RdE,
  input  logic                     RegWriteE,
  input  logic                     MemEnE,
  input  logic                     MemWriteE,
  input  logic [REG_ADDR_BITS-1:0] RdM,
  input  logic                     RegWriteM,
  input  logic                     MemEnM,
  input  logic [REG_ADDR_BITS-1:0] RdW,
  input  logic                     RegWriteW,
  input  logic                     PCRedirectE,
  input  logic                     MemReady,
  output logic [1:0]               ForwardAE,
  output logic [1:0]               ForwardBE,
  output logic                     StallF,
  output logic                     StallD,
  output logic                     StallE,
  output logic                     StallM,
  output logic                     FlushD,
  output logic                     FlushE,
  output logic                     FlushW,
  output logic                     MemReqM,
  output logic                     MemError,
  output logic [CNT_BITS-1:0]      StallCount
);

  localparam int TW = $clog2(MEM_TIMEOUT) + 1;

  forwardSrc       fwd_a, fwd_b;
  memState         state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic            mem_req, mem_stall, load_use, any_stall;

  forwarding_unit #(.REG_ADDR_BITS(REG_ADDR_BITS)) u_fwd_a (
    .rs(Rs1E), .rd_m(RdM), .reg_write_m(RegWriteM),
    .rd_w(RdW), .reg_write_w(RegWriteW), .fwd(fwd_a)
  );

  forwarding_unit #(.REG_ADDR_BITS(REG_ADDR_BITS)) u_fwd_b (
    .rs(Rs2E), .rd_m(RdM), .reg_write_m(RegWriteM),
    .rd_w(RdW), .reg_write_w(RegWriteW), .fwd(fwd_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
    end
  end

  // Timer counts stalled cycles of the request, including the IDLE cycle that first misses.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    mem_req   = 1'b0;
    mem_stall = 1'b0;
    unique case (state)
      IDLE: begin
        mem_req = MemEnM;
        timer_n = '0;
        if (MemEnM && !MemReady) begin
          state_n   = WAIT;
          timer_n   = TW'(1);
          mem_stall = 1'b1;
        end
      end
      WAIT: begin
        mem_req   = 1'b1;
        mem_stall = !MemReady;
        if (MemReady) begin
          state_n = IDLE;
          timer_n = '0;
        end else if (timer == TW'(MEM_TIMEOUT - 1)) begin
          state_n = ERROR;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      ERROR: begin
        mem_stall = 1'b1;
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

  assign load_use = MemEnE && !MemWriteE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // Memory freeze overrides everything; held instructions re-evaluate their hazards on release.
  always_comb begin
    ForwardAE = fwd_a;
    ForwardBE = fwd_b;
    StallF    = mem_stall || (load_use && !PCRedirectE);
    StallD    = mem_stall || (load_use && !PCRedirectE);
    StallE    = mem_stall;
    StallM    = mem_stall;
    FlushD    = PCRedirectE && !mem_stall;
    FlushE    = (PCRedirectE || load_use) && !mem_stall;
    FlushW    = mem_stall;
    MemReqM   = mem_req;
    if (reset) begin
      ForwardAE = RegFile;
      ForwardBE = RegFile;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
      MemReqM   = 1'b0;
    end
  end

  assign MemError  = (state == ERROR);
  assign any_stall = StallF || StallD || StallE || StallM;

  always_ff @(posedge clk) begin
    if (reset)
      StallCount <= '0;
    else if (any_stall && (StallCount != '1))
      StallCount <= StallCount + CNT_BITS'(1);
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - scoreboard bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;

  localparam logic [1:0] RF = 2'b00, WB = 2'b01, MF = 2'b10;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteE, MemEnE, MemWriteE, RegWriteM, MemEnM, RegWriteW, PCRedirectE, MemReady;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemReqM, MemError;
  logic [15:0] StallCount;

  typedef struct {
    string       tag;
    logic [12:0] outs;
    int          cnt;
  } exp_t;

  exp_t sb[$];
  int   exp_cnt = 0;
  int   errors = 0;
  int   checks = 0;

  pipeline_hazard_controller #(.REG_ADDR_BITS(5), .MEM_TIMEOUT(4), .CNT_BITS(16)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemEnE(MemEnE), .MemWriteE(MemWriteE),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemEnM(MemEnM),
    .RdW(RdW), .RegWriteW(RegWriteW), .PCRedirectE(PCRedirectE), .MemReady(MemReady),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemReqM(MemReqM), .MemError(MemError), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // outs = {ForwardAE, ForwardBE, Stall F/D/E/M, Flush D/E/W, MemReqM, MemError}
  function automatic logic [12:0] ex(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [3:0] st, input logic [2:0] fl,
                                     input logic [1:0] mm);
    return {fa, fb, st, fl, mm};
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [12:0] o;
      e = sb.pop_front();
      o = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemReqM, MemError};
      check({e.tag, ".fwd"},   32'(o[12:9]), 32'(e.outs[12:9]));
      check({e.tag, ".stall"}, 32'(o[8:5]),  32'(e.outs[8:5]));
      check({e.tag, ".flush"}, 32'(o[4:2]),  32'(e.outs[4:2]));
      check({e.tag, ".mem"},   32'(o[1:0]),  32'(e.outs[1:0]));
      check({e.tag, ".cnt"},   32'(StallCount), 32'(e.cnt));
    end
  end

  task automatic clr();
    reset = 0; Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteE = 0; MemEnE = 0; MemWriteE = 0; RegWriteM = 0; MemEnM = 0;
    RegWriteW = 0; PCRedirectE = 0; MemReady = 0;
  endtask

  task automatic step(input string tag, input logic [12:0] outs);
    exp_t e;
    e.tag = tag; e.outs = outs; e.cnt = exp_cnt;
    sb.push_back(e);
    if (reset) exp_cnt = 0;
    else if (outs[8:5] != 4'b0) exp_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    clr();
    reset = 1;
    @(posedge clk); #1;

    step("reset", ex(RF, RF, 4'b0000, 3'b111, 2'b00));

    clr(); RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
    step("fwd_mem_prio", ex(MF, RF, 4'b0000, 3'b000, 2'b00));
    RdM = 0;
    step("fwd_wb", ex(WB, RF, 4'b0000, 3'b000, 2'b00));
    clr(); Rs2E = 0; RdW = 0; RegWriteW = 1;
    step("fwd_x0", ex(RF, RF, 4'b0000, 3'b000, 2'b00));
    clr(); Rs2E = 9; RdM = 9; RegWriteM = 0; RdW = 9; RegWriteW = 1;
    step("fwd_b_wb", ex(RF, WB, 4'b0000, 3'b000, 2'b00));

    clr(); MemEnE = 1; RdE = 7; Rs2D = 7;
    step("load_use", ex(RF, RF, 4'b1100, 3'b010, 2'b00));
    clr();
    step("load_use_after", ex(RF, RF, 4'b0000, 3'b000, 2'b00));
    MemEnE = 1; RdE = 0; Rs2D = 0;
    step("load_x0", ex(RF, RF, 4'b0000, 3'b000, 2'b00));
    MemEnE = 1; MemWriteE = 1; RdE = 7; Rs1D = 7;
    step("store_no_stall", ex(RF, RF, 4'b0000, 3'b000, 2'b00));
    clr(); MemEnE = 1; RdE = 7; Rs1D = 7; PCRedirectE = 1;
    step("lu_redirect", ex(RF, RF, 4'b0000, 3'b110, 2'b00));

    clr(); MemEnM = 1;
    step("wait_c1", ex(RF, RF, 4'b1111, 3'b001, 2'b10));
    PCRedirectE = 1; MemEnE = 1; RdE = 3; Rs1D = 3; Rs1E = 5; RdM = 5; RegWriteM = 1;
    step("wait_c2_redir", ex(MF, RF, 4'b1111, 3'b001, 2'b10));
    clr(); MemEnM = 1;
    step("wait_c3", ex(RF, RF, 4'b1111, 3'b001, 2'b10));
    MemReady = 1;
    step("wait_ready", ex(RF, RF, 4'b0000, 3'b000, 2'b10));
    clr();
    step("wait_done", ex(RF, RF, 4'b0000, 3'b000, 2'b00));
    MemEnM = 1; MemReady = 1;
    step("zero_wait", ex(RF, RF, 4'b0000, 3'b000, 2'b10));

    clr(); MemEnM = 1;
    step("to_c1", ex(RF, RF, 4'b1111, 3'b001, 2'b10));
    step("to_c2", ex(RF, RF, 4'b1111, 3'b001, 2'b10));
    step("to_c3", ex(RF, RF, 4'b1111, 3'b001, 2'b10));
    step("to_c4", ex(RF, RF, 4'b1111, 3'b001, 2'b10));
    step("error_1", ex(RF, RF, 4'b1111, 3'b001, 2'b01));
    clr(); MemReady = 1;
    step("error_2", ex(RF, RF, 4'b1111, 3'b001, 2'b01));
    clr(); reset = 1; Rs1E = 5; RdM = 5; RegWriteM = 1;
    step("error_reset", ex(RF, RF, 4'b0000, 3'b111, 2'b01));
    clr();
    step("post_err_reset", ex(RF, RF, 4'b0000, 3'b000, 2'b00));

    MemEnM = 1;
    step("rw_c1", ex(RF, RF, 4'b1111, 3'b001, 2'b10));
    reset = 1;
    step("rw_reset", ex(RF, RF, 4'b0000, 3'b111, 2'b00));
    clr(); MemEnM = 1; MemReady = 1;
    step("rw_zero_wait", ex(RF, RF, 4'b0000, 3'b000, 2'b10));
    clr();
    step("final_idle", ex(RF, RF, 4'b0000, 3'b000, 2'b00));

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
